edge_period_meter: RTL and testbench
====================================

// Module: edge_period_meter
// PURPOSE
//  Downstream monitor for the divide-by-2 clock stage: samples the divided
//  output (sig_in) in the source clk domain and measures its period and high
//  time in clk cycles. Flags a stuck or too-slow divider output and counts
//  completed measurements. Used in-system and in benches for self-checking.
// PARAMETERS
//  CNT_W   16  width of period/high_time counters; max count = 2^CNT_W-1
//  MCNT_W  8   width of meas_count
// PORTS
//  clk         in   1       system clock; same clock that drives the divider
//  rst         in   1       synchronous, active-low reset
//  en          in   1       measurement enable
//  sig_in      in   1       signal under test; clk-synchronous, no synchronizer
//  period      out  CNT_W   clk cycles between the last two rising edges
//  high_time   out  CNT_W   cycles sig_in sampled high within that period
//  meas_valid  out  1       1-cycle pulse: period/high_time just updated
//  stuck       out  1       no rising edge within 2^CNT_W-1 cycles
//  meas_count  out  MCNT_W  number of completed measurements, wraps
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; period, high_time, meas_count,
//   cnt, hi_cnt = 0; meas_valid, stuck = 0; sig_d = 1 (no false edge).
//  Edge detect: sig_d <= sig_in every cycle, in every state.
//   rise = sig_in & ~sig_d.
//  FSM:
//   IDLE:    en=1 -> ARM. Otherwise stay.
//   ARM:     rise -> MEASURE with cnt=1, hi_cnt=1. No output update.
//   MEASURE: rise -> period<=cnt, high_time<=hi_cnt, meas_valid<=1,
//             stuck<=0, meas_count++, cnt<=1, hi_cnt<=1.
//            No rise, cnt==2^CNT_W-1 -> stuck<=1, go to ARM.
//            Otherwise cnt++, and hi_cnt += sig_in.
//   In any state, en=0 -> IDLE next cycle; cnt and hi_cnt cleared;
//    period, high_time, stuck and meas_count hold.
//  Priority: rst > en=0 > rise > saturation.
//   If rise and cnt==max occur together, the measurement is taken with
//   period=max and stuck stays 0.
//  All outputs are registered. meas_valid is high for the cycle after the
//   clk edge at which the rising edge was sampled. It is never high for
//   2 consecutive cycles, because the minimum period is 2.
//  First measurement after reset or enable needs two rising edges.
//  A high level when the block arms is not an edge.
//  hi_cnt cannot exceed cnt, so no overflow beyond the cnt saturation.
//  meas_count wraps from 2^MCNT_W-1 to 0.
//  Reset mid-MEASURE discards the partial count. No meas_valid follows
//   until two fresh rising edges after reset release.
// TESTING
//  1. Reset 20ns, en=1, sig_in = divide-by-2 output of clk (10ns clk) ->
//     after 2nd rise: period=2, high_time=1, meas_valid every 2nd cycle,
//     meas_count increments each time.
//  2. sig_in periodic, 3 cycles high and 7 low ->
//     period=10, high_time=3, stuck=0.
//  3. CNT_W=4, one rise then sig_in held 1 -> stuck=1 exactly 15 cycles
//     after the rise, with no meas_valid. Then resume 2-cycle toggling ->
//     stuck=0 on the first new meas_valid.
//  4. en=0 mid-MEASURE for 5 cycles, then en=1 -> no meas_valid while
//     disabled; outputs hold; first new valid only after 2 rises.
//  5. rst=0 while sig_in=1 mid-measure, release with sig_in=1 -> all
//     outputs 0, no false rise, first valid on the 2nd real rise.
//  6. 257 measurements with MCNT_W=8 -> meas_count reads 255, then 0, then 1.

Source files
------------

// File: rtl/edge_period_meter.sv
// Period and high-time meter for a clk-synchronous signal (divide-by-2 monitor).
// Flags a missing rising edge after 2^CNT_W-1 cycles and counts completed measurements.
module edge_period_meter #(
    parameter int CNT_W  = 16,
    parameter int MCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sig_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic              meas_valid,
    output logic              stuck,
    output logic [MCNT_W-1:0] meas_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_next;
    logic               r_sig_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hi_cnt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high_time;
    logic               r_meas_valid;
    logic               r_stuck;
    logic [MCNT_W-1:0]  r_meas_count;
    logic               w_rise;
    logic               w_sat;
    logic               w_take;
    logic               w_timeout;

    assign w_rise = sig_in & ~r_sig_d;
    assign w_sat  = (r_cnt == CNT_MAX);

    always_comb begin
        w_next    = r_state;
        w_take    = 1'b0;
        w_timeout = 1'b0;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next = S_ARM;
                S_ARM:     if (w_rise) w_next = S_MEASURE;
                S_MEASURE: begin
                    // A rise on the saturating cycle still counts as a measurement.
                    if (w_rise) begin
                        w_take = 1'b1;
                    end else if (w_sat) begin
                        w_timeout = 1'b1;
                        w_next    = S_ARM;
                    end
                end
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sig_d      <= 1'b1;
            r_cnt        <= '0;
            r_hi_cnt     <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
            r_meas_count <= '0;
        end else begin
            r_state      <= w_next;
            r_sig_d      <= sig_in;
            r_meas_valid <= w_take;
            if (!en) begin
                r_cnt    <= '0;
                r_hi_cnt <= '0;
            end else if (r_state == S_ARM && w_rise) begin
                r_cnt    <= CNT_W'(1);
                r_hi_cnt <= CNT_W'(1);
            end else if (w_take) begin
                r_period     <= r_cnt;
                r_high_time  <= r_hi_cnt;
                r_stuck      <= 1'b0;
                r_meas_count <= r_meas_count + MCNT_W'(1);
                r_cnt        <= CNT_W'(1);
                r_hi_cnt     <= CNT_W'(1);
            end else if (w_timeout) begin
                r_stuck  <= 1'b1;
                r_cnt    <= '0;
                r_hi_cnt <= '0;
            end else if (r_state == S_MEASURE) begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_hi_cnt <= r_hi_cnt + CNT_W'(sig_in);
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign stuck      = r_stuck;
    assign meas_count = r_meas_count;

endmodule

// File: tb/tb_edge_period_meter.sv
// Scoreboard bench for edge_period_meter: expected measurements are queued as
// rising edges are driven and checked when meas_valid fires.
module tb_edge_period_meter;

    localparam int CNT_W  = 4;
    localparam int MCNT_W = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic              sig_in;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  high_time;
    logic              meas_valid;
    logic              stuck;
    logic [MCNT_W-1:0] meas_count;

    edge_period_meter #(
        .CNT_W  (CNT_W),
        .MCNT_W (MCNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .stuck      (stuck),
        .meas_count (meas_count)
    );

    typedef struct {
        int unsigned due;
        int unsigned period;
        int unsigned high;
        int unsigned count;
    } exp_t;

    exp_t              sb[$];
    int unsigned       n_tests = 0;
    int unsigned       n_fail  = 0;
    int unsigned       cyc     = 0;
    bit                have_prev;
    int unsigned       prev_hi;
    int unsigned       prev_lo;
    int unsigned       exp_period;
    int unsigned       exp_high;
    logic [MCNT_W-1:0] exp_count;
    bit                exp_stuck;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("valid_time", cyc, e.due);
                check_eq("period", period, e.period);
                check_eq("high_time", high_time, e.high);
                check_eq("meas_count", meas_count, e.count);
                check_eq("stuck_on_valid", stuck, 0);
            end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            check_eq("missing_valid", 0, 1);
            sb.delete(0);
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        have_prev  = 1'b0;
        prev_hi    = 0;
        prev_lo    = 0;
        exp_period = 0;
        exp_high   = 0;
        exp_count  = '0;
        exp_stuck  = 1'b0;
        sb.delete();
    endtask

    // Called just before a rise is driven; the pulse shape that follows is (hi, lo).
    task automatic note_rise(input int unsigned hi, input int unsigned lo);
        if (have_prev) begin
            exp_period = prev_hi + prev_lo;
            exp_high   = prev_hi;
            exp_count  = exp_count + 1'b1;
            exp_stuck  = 1'b0;
            sb.push_back('{cyc + 1, exp_period, exp_high, int'(exp_count)});
        end
        have_prev = 1'b1;
        prev_hi   = hi;
        prev_lo   = lo;
    endtask

    task automatic pulse(input int unsigned hi, input int unsigned lo);
        note_rise(hi, lo);
        sig_in = 1'b1;
        step(hi);
        sig_in = 1'b0;
        step(lo);
    endtask

    task automatic check_hold(input string tag);
        check_eq({tag, "_period"}, period, exp_period);
        check_eq({tag, "_high"}, high_time, exp_high);
        check_eq({tag, "_count"}, meas_count, exp_count);
        check_eq({tag, "_stuck"}, stuck, exp_stuck);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        reset_model();
        step(2);
        check_hold("reset");
        check_eq("reset_valid", meas_valid, 0);
        rst = 1'b1;
        en  = 1'b1;
        step(1);

        // divide-by-2 input
        repeat (6) pulse(1, 1);
        check_eq("t1_period", period, 2);
        check_eq("t1_high", high_time, 1);
        check_eq("t1_count", meas_count, 5);

        // 3 high / 7 low
        repeat (4) pulse(3, 7);
        check_eq("t2_period", period, 10);
        check_eq("t2_high", high_time, 3);
        check_eq("t2_stuck", stuck, 0);

        // rise coincides with counter saturation
        repeat (3) pulse(5, 10);
        check_eq("max_period", period, 15);
        check_eq("max_stuck", stuck, 0);

        // stuck high after a rise
        pulse(1, 1);
        pulse(1, 1);
        note_rise(0, 0);
        sig_in = 1'b1;
        step(15);
        check_eq("stuck_early", stuck, 0);
        step(1);
        check_eq("stuck_set", stuck, 1);
        have_prev = 1'b0;
        exp_stuck = 1'b1;
        step(3);
        check_hold("stuck_hold");
        sig_in = 1'b0;
        step(1);
        pulse(1, 1);
        check_eq("stuck_armed", stuck, 1);
        pulse(1, 1);
        pulse(1, 1);
        check_eq("stuck_cleared", stuck, 0);

        // disable mid-measure; the rise on the disabling cycle must be ignored
        en        = 1'b0;
        sig_in    = 1'b1;
        have_prev = 1'b0;
        step(1);
        repeat (4) begin
            sig_in = ~sig_in;
            step(1);
        end
        check_hold("disabled");
        en     = 1'b1;
        sig_in = 1'b0;
        step(1);
        pulse(2, 2);
        check_hold("reen_armed");
        pulse(2, 2);
        pulse(2, 2);
        check_eq("reen_period", period, 4);

        // reset mid-measure with sig_in high, release while still high
        pulse(1, 3);
        note_rise(3, 3);
        sig_in = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        reset_model();
        check_hold("rst_mid");
        check_eq("rst_mid_valid", meas_valid, 0);
        rst = 1'b1;
        step(2);
        check_hold("rst_rel");
        sig_in = 1'b0;
        step(1);

        // 257 measurements: count passes 255 -> 0 -> 1
        repeat (258) pulse(1, 1);
        check_eq("wrap_count", meas_count, 1);

        step(3);
        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
